stream_mux_n: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every channel. Supersedes the fixed 4:1 single-bit combinational mux. Adds selectable arbitration: explicit select or round-robin. Sits between multiple producer streams and a single consumer in the data-flow datapath.

---
 rtl/stream_mux_pkg.sv | 8 +
 rtl/stream_mux_n_rr_arbiter.sv | 29 ++
 rtl/stream_mux_n.sv | 48 ++++
 tb/tb_stream_mux_n.sv | 108 ++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode encodings and channel-index width helper
package stream_mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
  function automatic int selw(input int channels);
    return ($clog2(channels) > 1) ? $clog2(channels) : 1;
  endfunction
endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rr_arbiter: rotating-priority grant search with a next-start pointer
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SELW = selw(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic                grant_valid,
  output logic [SELW-1:0]     grant
);
  logic [SELW-1:0] ptr;
  // Scan from the far end backwards so the channel nearest ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % CHANNELS]) begin
        grant_valid = 1'b1;
        grant = SELW'((int'(ptr) + i) % CHANNELS);
      end
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel valid/ready mux with select or round-robin arbitration and a registered output
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SELW = selw(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic accept, sel_ok, rr_v, gv, xfer;
  logic [SELW-1:0] rr_g, g;
  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(in_valid),
    .advance(xfer && mode == MODE_RR),
    .grant_valid(rr_v),
    .grant(rr_g)
  );
  assign accept = !out_valid || out_ready;
  // Shift-based lookup keeps an out-of-range sel from indexing past the vector.
  assign sel_ok = (int'(sel) < CHANNELS) && |(in_valid & (CHANNELS'(1) << sel));
  assign gv = (mode == MODE_RR) ? rr_v : sel_ok;
  assign g = (mode == MODE_RR) ? rr_g : sel;
  assign xfer = rst_n && gv && accept;
  assign in_ready = xfer ? (CHANNELS'(1) << g) : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= WIDTH'(in_data >> (int'(g) * WIDTH));
      out_chan <= g;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: table-driven directed checks of stream_mux_n, plus a 3-channel instance for out-of-range select
module tb_stream_mux_n;
  typedef struct {
    logic rst_n; logic mode; logic [1:0] sel; logic [3:0] iv; logic [31:0] d; logic ordy;
    logic [3:0] ir; logic ov; logic [7:0] od; logic [1:0] oc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, mode, out_ready, out_valid;
  logic [1:0] sel, out_chan;
  logic [31:0] in_data;
  logic [3:0] in_valid, in_ready;
  logic [7:0] out_data;
  logic rst3_n, mode3, out_ready3, out_valid3;
  logic [1:0] sel3, out_chan3;
  logic [23:0] in_data3;
  logic [2:0] in_valid3, in_ready3;
  logic [7:0] out_data3;
  int checks = 0, errors = 0;
  vec_t v[25];
  always #5 clk = ~clk;
  stream_mux_n #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );
  stream_mux_n #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s, input logic [3:0] iv,
      input logic [31:0] d, input logic o, input logic [3:0] ir, input logic ov, input logic [7:0] od, input logic [1:0] oc);
    vec_t t;
    t.rst_n = r; t.mode = m; t.sel = s; t.iv = iv; t.d = d; t.ordy = o;
    t.ir = ir; t.ov = ov; t.od = od; t.oc = oc;
    return t;
  endfunction
  task automatic step3(input int idx, input logic r, input logic m, input logic [1:0] s, input logic [2:0] iv,
      input logic [2:0] ir, input logic ov, input logic [7:0] od, input logic [1:0] oc);
    @(negedge clk);
    rst3_n = r; mode3 = m; sel3 = s; in_valid3 = iv;
    #1 chk("c3_in_ready", idx, 32'(in_ready3), 32'(ir));
    @(posedge clk);
    #1;
    chk("c3_out_valid", idx, 32'(out_valid3), 32'(ov));
    if (ov) begin
      chk("c3_out_data", idx, 32'(out_data3), 32'(od));
      chk("c3_out_chan", idx, 32'(out_chan3), 32'(oc));
    end
  endtask
  initial begin
    localparam logic [31:0] D = 32'h44332211;
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    rst3_n = 1'b0; mode3 = 1'b0; sel3 = '0; in_data3 = 24'h776655; in_valid3 = '0; out_ready3 = 1'b1;
    //          rst mode sel iv       data          ordy ir       ov  od     oc
    v[0]  = mk(0, 0, 0, 4'b1111, D,            1, 4'b0000, 0, 8'h00, 0);
    v[1]  = mk(1, 0, 2, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2);
    v[2]  = mk(1, 0, 1, 4'b0000, D,            1, 4'b0000, 0, 8'hA5, 2);
    v[3]  = mk(1, 0, 3, 4'b0111, D,            1, 4'b0000, 0, 8'hA5, 2);
    v[4]  = mk(1, 0, 3, 4'b1000, D,            0, 4'b1000, 1, 8'h44, 3);
    v[5]  = mk(1, 1, 0, 4'b1111, D,            1, 4'b0001, 1, 8'h11, 0);
    v[6]  = mk(1, 1, 0, 4'b1111, D,            1, 4'b0010, 1, 8'h22, 1);
    v[7]  = mk(1, 1, 0, 4'b1111, D,            1, 4'b0100, 1, 8'h33, 2);
    v[8]  = mk(1, 1, 0, 4'b1111, D,            1, 4'b1000, 1, 8'h44, 3);
    v[9]  = mk(1, 1, 0, 4'b1111, D,            1, 4'b0001, 1, 8'h11, 0);
    v[10] = mk(1, 1, 0, 4'b1010, D,            1, 4'b0010, 1, 8'h22, 1);
    v[11] = mk(1, 1, 0, 4'b1010, D,            1, 4'b1000, 1, 8'h44, 3);
    v[12] = mk(1, 1, 0, 4'b1010, D,            1, 4'b0010, 1, 8'h22, 1);
    v[13] = mk(1, 0, 0, 4'b0001, 32'h4433223C, 1, 4'b0001, 1, 8'h3C, 0);
    v[14] = mk(1, 1, 0, 4'b1111, D,            0, 4'b0000, 1, 8'h3C, 0);
    v[15] = mk(1, 1, 0, 4'b1111, D,            0, 4'b0000, 1, 8'h3C, 0);
    v[16] = mk(1, 1, 0, 4'b1111, D,            0, 4'b0000, 1, 8'h3C, 0);
    v[17] = mk(1, 1, 0, 4'b1111, D,            1, 4'b0100, 1, 8'h33, 2);
    v[18] = mk(1, 0, 0, 4'b1111, D,            1, 4'b0001, 1, 8'h11, 0);
    v[19] = mk(1, 1, 0, 4'b1111, D,            1, 4'b1000, 1, 8'h44, 3);
    v[20] = mk(1, 1, 0, 4'b0000, D,            0, 4'b0000, 1, 8'h44, 3);
    v[21] = mk(1, 1, 0, 4'b0000, D,            1, 4'b0000, 0, 8'h44, 3);
    v[22] = mk(1, 1, 0, 4'b1111, D,            1, 4'b0001, 1, 8'h11, 0);
    v[23] = mk(0, 1, 0, 4'b1111, D,            1, 4'b0000, 0, 8'h00, 0);
    v[24] = mk(1, 1, 0, 4'b1111, D,            1, 4'b0001, 1, 8'h11, 0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst_n = v[i].rst_n; mode = v[i].mode; sel = v[i].sel;
      in_valid = v[i].iv; in_data = v[i].d; out_ready = v[i].ordy;
      #1 chk("in_ready", i, 32'(in_ready), 32'(v[i].ir));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(v[i].ov));
      chk("out_data", i, 32'(out_data), 32'(v[i].od));
      chk("out_chan", i, 32'(out_chan), 32'(v[i].oc));
    end
    // Three channels: sel=3 is representable but out of range and must never grant.
    step3(0, 0, 0, 0, 3'b111, 3'b000, 0, 8'h00, 0);
    step3(1, 1, 0, 3, 3'b111, 3'b000, 0, 8'h00, 0);
    step3(2, 1, 0, 2, 3'b111, 3'b100, 1, 8'h77, 2);
    step3(3, 1, 1, 0, 3'b111, 3'b001, 1, 8'h55, 0);
    step3(4, 1, 1, 0, 3'b100, 3'b100, 1, 8'h77, 2);
    step3(5, 1, 1, 0, 3'b111, 3'b001, 1, 8'h55, 0);
    step3(6, 1, 1, 3, 3'b000, 3'b000, 0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
